// File: rtl/flit_route_ctrl_if.sv
// Handshake bundle between an input-port FIFO, the switch allocator and the crossbar.
// master = route controller side, slave = surrounding router fabric.
interface flit_route_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;
    logic [4:0]            req;
    logic                  grant;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  err_type;
    logic                  err_len;

    modport master (
        input  fifo_empty, fifo_data, grant, out_ready,
        output fifo_rd_en, req, out_data, out_valid, busy, err_type, err_len
    );

    modport slave (
        output fifo_empty, fifo_data, grant, out_ready,
        input  fifo_rd_en, req, out_data, out_valid, busy, err_type, err_len
    );
endinterface

// File: rtl/flit_route_ctrl.sv
// Input-port route controller: XY-routes a packet header, requests an output port,
// then streams the packet to the crossbar with wormhole flow control.
module flit_route_ctrl #(
    parameter int         DATA_WIDTH = 32,
    parameter logic [3:0] CUR_ADDR   = 4'h5,
    parameter int         LEN_WIDTH  = 12
) (
    input  logic              clk,
    input  logic              rst,
    flit_route_ctrl_if.master port
);
    localparam logic [2:0] TYPE_HEADER  = 3'b001;
    localparam logic [2:0] TYPE_PAYLOAD = 3'b010;
    localparam logic [2:0] TYPE_TAIL    = 3'b100;

    localparam logic [4:0] PORT_L = 5'b00001;
    localparam logic [4:0] PORT_N = 5'b00010;
    localparam logic [4:0] PORT_E = 5'b00100;
    localparam logic [4:0] PORT_S = 5'b01000;
    localparam logic [4:0] PORT_W = 5'b10000;

    typedef enum logic [1:0] {IDLE, REQ, FWD} state_t;

    state_t               state_reg, state_next;
    logic [4:0]           route_reg, route_calc;
    logic [LEN_WIDTH-1:0] len_reg, cnt_reg, cnt_inc;
    logic                 err_type_reg, err_len_reg;

    logic [2:0] head_type;
    logic [3:0] d_addr;
    logic       head_is_hdr, head_is_tail, drop, xfer, rd_en, valid, fwd_active;
    logic [4:0] req_comb;

    assign head_type    = port.fifo_data[DATA_WIDTH-1 -: 3];
    assign d_addr       = port.fifo_data[16:13];
    assign head_is_hdr  = (head_type == TYPE_HEADER);
    assign head_is_tail = (head_type == TYPE_TAIL);
    assign cnt_inc      = cnt_reg + 1'b1;
    assign fwd_active   = (state_reg == FWD);

    // Dimension-order routing: resolve X first, then Y, else deliver locally.
    always_comb begin
        route_calc = PORT_L;
        if (d_addr[3:2] > CUR_ADDR[3:2])
            route_calc = PORT_E;
        else if (d_addr[3:2] < CUR_ADDR[3:2])
            route_calc = PORT_W;
        else if (d_addr[1:0] > CUR_ADDR[1:0])
            route_calc = PORT_S;
        else if (d_addr[1:0] < CUR_ADDR[1:0])
            route_calc = PORT_N;
    end

    always_comb begin
        state_next = state_reg;
        req_comb   = 5'b00000;
        valid      = 1'b0;
        xfer       = 1'b0;
        drop       = 1'b0;
        rd_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!port.fifo_empty) begin
                    if (head_is_hdr)
                        state_next = REQ;
                    else
                        drop = 1'b1;
                end
                rd_en = drop;
            end
            REQ: begin
                req_comb = route_reg;
                if (port.grant)
                    state_next = FWD;
            end
            FWD: begin
                req_comb = route_reg;
                valid    = ~port.fifo_empty;
                xfer     = valid & port.out_ready;
                rd_en    = xfer;
                if (xfer && head_is_tail)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Keep the FIFO untouched while reset is held, even if a stray flit sits at its head.
        if (!rst)
            rd_en = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            route_reg    <= 5'b00000;
            len_reg      <= '0;
            cnt_reg      <= '0;
            err_type_reg <= 1'b0;
            err_len_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            err_type_reg <= drop;
            err_len_reg  <= xfer & head_is_tail & (cnt_inc != len_reg);
            if (state_reg == IDLE && !port.fifo_empty && head_is_hdr) begin
                route_reg <= route_calc;
                len_reg   <= port.fifo_data[17 +: LEN_WIDTH];
                cnt_reg   <= '0;
            end else if (xfer) begin
                cnt_reg <= cnt_inc;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_out_data
            assign port.out_data[gi] = fwd_active & port.fifo_data[gi];
        end
    endgenerate

    assign port.fifo_rd_en = rd_en;
    assign port.req        = req_comb;
    assign port.out_valid  = valid;
    assign port.busy       = (state_reg != IDLE);
    assign port.err_type   = err_type_reg;
    assign port.err_len    = err_len_reg;

    // Payload code is named for readability of the type map; only HEADER/TAIL steer control.
    logic unused_type_code;
    assign unused_type_code = ^TYPE_PAYLOAD;
endmodule
